srec_dumper: RTL and testbench
==============================

Name: srec_dumper

Overview:
- Reads a range of instruction/data memory through the mem_controller port and emits it as Motorola S-record ASCII text: one S3 record per RECORD_BYTES, then one S7 termination record.
- It is the output-side counterpart of srec_parser. The bench uses it after a writeback-stage run to dump memory for comparison against a golden .srec file.
- The bench muxes it onto mcu's address/wren/data_in the same way srec_parser is muxed.

Parameters:
- RECORD_BYTES, 16: data bytes per S3 record. Must be a multiple of 4 and no greater than 32.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle request; ignored while busy
- start_address  in  [0:31]  first byte address, word-aligned; latched on start
- length  in  [0:31]  byte count, multiple of 4; latched on start; 0 is legal
- mem_address  out  [0:31]  word read address to mem_controller
- mem_wren  out  1  tied 0 (read-only master)
- mem_data_in  out  [0:31]  tied 0
- mem_data_out  in  [0:31]  read data; big-endian, byte0 = bits [0:7]
- char_out  out  [7:0]  ASCII character
- char_valid  out  1  char_out holds a character
- char_ready  in  1  sink accepts char_out this cycle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final character is accepted

Behaviour:
- Reset: reset_n=0 at a rising edge is honoured in any state, mid-record included.
  - Outputs: mem_address=0, char_out=0, char_valid=0, busy=0, done=0; state=IDLE.
  - Internal buffer, counters and checksum cleared; any partially sent record is abandoned.
- Memory read latency: a word is sampled from mem_data_out at the second rising edge after mem_address is driven (1 cycle of latency).
- FSM states: IDLE, FETCH, S_CHAR, TYPE, COUNT, ADDR, DATA, CSUM, EOL, DONE.
  - IDLE -> FETCH when start=1, or -> S_CHAR (S7 path) when start=1 and length=0.
  - FETCH: reads N = min(RECORD_BYTES, remaining) bytes, as N/4 words, into the record buffer. Words are issued back-to-back; the address advances by 4.
  - Then S_CHAR 'S' -> TYPE ('3', or '7' for the terminator) -> COUNT -> ADDR -> DATA (skipped for S7) -> CSUM -> EOL.
  - After EOL: back to FETCH if bytes remain, else to the S7 record, else DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Record formats:
  - S3: "S3" CC AAAAAAAA DD..DD KK LF (0x0A).
  - S7: "S705" AAAAAAAA KK LF, where AAAAAAAA = the latched start_address.
- Field rules:
  - Hex digits are uppercase ASCII ('0'-'9', 'A'-'F'); each byte is emitted high nibble first.
  - CC = N+5 for S3 and 0x05 for S7.
  - Address is the record's first byte address, 8 hex digits, MSB first.
  - KK = bitwise NOT of the low 8 bits of the sum of CC, the 4 address bytes and the N data bytes. The sum accumulates mod 256.
- Final record: if length is not a multiple of RECORD_BYTES, the last S3 record carries the remainder (N<RECORD_BYTES) and CC is adjusted to match.
- Handshake:
  - A character transfers on a rising edge where char_valid=1 and char_ready=1.
  - While char_valid=1 and char_ready=0, char_out and all state hold.
  - char_ready may stay high permanently, giving 1 character/cycle with no bubbles inside a record.
  - char_valid is 0 during FETCH.
- Address arithmetic wraps modulo 2^32. No bounds checking is done.
- start pulses arriving while busy=1 are ignored. A start in the same cycle as the done pulse is also ignored; the next start is accepted from IDLE.

Test Plan:
- start_address=0x80020000, length=4, mem[0x80020000]=0x27BDFFF8, char_ready=1 -> "S3098002000027BDFFF899\n" then "S7058002000078\n", then a one-cycle done pulse. mem_wren stays 0 throughout.
- length=0, start_address=0x80020000 -> only "S7058002000078\n"; no memory reads issued; done pulses.
- length=20 -> first record "S315" at 0x80020000 with 32 data digits; second record "S309" at 0x80020010 with 8 data digits; then S7; checksums match the reference model.
- Toggle char_ready pseudo-randomly through the length=20 dump -> character stream identical to the char_ready=1 run; char_out is stable whenever valid is high and ready is low.
- Assert reset_n=0 for one cycle mid-DATA -> next cycle char_valid=0, busy=0. A fresh start then produces a complete correct dump.
- Pulse start again while busy -> ignored; a single dump is emitted; exactly one done pulse.

Source files
------------

// File: rtl/srec_dumper.sv
// Reads a word-aligned memory range and streams it out as Motorola S-record text:
// one S3 record per RECORD_BYTES data bytes, followed by an S7 termination record.
`timescale 1ns/1ps
module srec_dumper #(
    parameter int RECORD_BYTES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [0:31] start_address,
    input  logic [0:31] length,
    output logic [0:31] mem_address,
    output logic        mem_wren,
    output logic [0:31] mem_data_in,
    input  logic [0:31] mem_data_out,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [3:0] {
        IDLE, FETCH, S_CHAR, TYPE, COUNT, ADDR, DATA, CSUM, EOL, DONE
    } state_t;

    localparam logic [5:0] REC_BYTES = 6'(RECORD_BYTES);

    state_t      state_q, state_d;
    logic [31:0] start_addr_q, start_addr_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [31:0] remaining_q, remaining_d;
    logic [5:0]  rec_bytes_q, rec_bytes_d;
    logic        is_s7_q, is_s7_d;
    logic [6:0]  dig_q, dig_d;
    logic [7:0]  sum_q, sum_d;
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [3:0]  recv_cnt_q, recv_cnt_d;
    logic        rd_v1_q, rd_v1_d;
    logic        rd_v2_q, rd_v2_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [7:0]  char_out_q, char_out_d;
    logic        char_valid_q, char_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] buf_q [0:7];
    logic [31:0] buf_d [0:7];

    logic [31:0] start_addr_in, length_in, mem_word_in;
    logic        advance;
    logic [7:0]  cc_q, cc_d, cur_byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  nibble_d;

    assign start_addr_in = start_address;
    assign length_in     = length;
    assign mem_word_in   = mem_data_out;

    function automatic logic [5:0] rec_size(input logic [31:0] rem);
        return (rem < 32'(RECORD_BYTES)) ? rem[5:0] : REC_BYTES;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Byte currently being rendered as two hex digits; dig selects byte and nibble.
    function automatic logic [7:0] byte_at(input state_t st, input logic [6:0] dig,
                                           input logic [7:0] cc, input logic [31:0] addr,
                                           input logic [31:0] word, input logic [7:0] sum);
        logic [31:0] addr_sh;
        logic [31:0] word_sh;
        addr_sh = addr << {dig[2:1], 3'b000};
        word_sh = word << {dig[2:1], 3'b000};
        case (st)
            COUNT:   return cc;
            ADDR:    return addr_sh[31:24];
            DATA:    return word_sh[31:24];
            CSUM:    return ~sum;
            default: return 8'h00;
        endcase
    endfunction

    assign advance    = char_valid_q && char_ready;
    assign cc_q       = is_s7_q ? 8'd5 : ({2'b00, rec_bytes_q} + 8'd5);
    assign addr_q     = is_s7_q ? start_addr_q : cur_addr_q;
    assign cur_byte_q = byte_at(state_q, dig_q, cc_q, addr_q, buf_q[dig_q[5:3]], sum_q);

    always_comb begin
        state_d       = state_q;
        start_addr_d  = start_addr_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        rec_bytes_d   = rec_bytes_q;
        is_s7_d       = is_s7_q;
        dig_d         = dig_q;
        sum_d         = sum_q;
        issue_cnt_d   = issue_cnt_q;
        recv_cnt_d    = recv_cnt_q;
        rd_v1_d       = 1'b0;
        rd_v2_d       = rd_v1_q;
        mem_address_d = mem_address_q;
        buf_d         = buf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    start_addr_d = start_addr_in;
                    cur_addr_d   = start_addr_in;
                    remaining_d  = length_in;
                    issue_cnt_d  = 4'd0;
                    recv_cnt_d   = 4'd0;
                    rec_bytes_d  = rec_size(length_in);
                    is_s7_d      = (length_in == 32'd0);
                    state_d      = (length_in == 32'd0) ? S_CHAR : FETCH;
                end
            end
            FETCH: begin
                // rd_v1/rd_v2 track each issued read through the one-cycle memory latency.
                if (issue_cnt_q < rec_bytes_q[5:2]) begin
                    mem_address_d = cur_addr_q + {26'd0, issue_cnt_q, 2'b00};
                    issue_cnt_d   = issue_cnt_q + 4'd1;
                    rd_v1_d       = 1'b1;
                end
                if (rd_v2_q) begin
                    buf_d[recv_cnt_q[2:0]] = mem_word_in;
                    recv_cnt_d             = recv_cnt_q + 4'd1;
                    if (recv_cnt_q + 4'd1 == rec_bytes_q[5:2]) begin
                        state_d = S_CHAR;
                    end
                end
            end
            S_CHAR: if (advance) begin
                state_d = TYPE;
                sum_d   = 8'd0;
                dig_d   = 7'd0;
            end
            TYPE: if (advance) begin
                state_d = COUNT;
                dig_d   = 7'd0;
            end
            COUNT: if (advance) begin
                dig_d = dig_q + 7'd1;
                if (dig_q[0]) begin
                    sum_d   = sum_q + cur_byte_q;
                    dig_d   = 7'd0;
                    state_d = ADDR;
                end
            end
            ADDR: if (advance) begin
                dig_d = dig_q + 7'd1;
                if (dig_q[0]) sum_d = sum_q + cur_byte_q;
                if (dig_q == 7'd7) begin
                    dig_d   = 7'd0;
                    state_d = is_s7_q ? CSUM : DATA;
                end
            end
            DATA: if (advance) begin
                dig_d = dig_q + 7'd1;
                if (dig_q[0]) sum_d = sum_q + cur_byte_q;
                if (dig_q == {rec_bytes_q, 1'b0} - 7'd1) begin
                    dig_d   = 7'd0;
                    state_d = CSUM;
                end
            end
            CSUM: if (advance) begin
                dig_d = dig_q + 7'd1;
                if (dig_q[0]) state_d = EOL;
            end
            EOL: if (advance) begin
                if (is_s7_q) begin
                    state_d = DONE;
                end else begin
                    cur_addr_d  = cur_addr_q + {26'd0, rec_bytes_q};
                    remaining_d = remaining_q - {26'd0, rec_bytes_q};
                    issue_cnt_d = 4'd0;
                    recv_cnt_d  = 4'd0;
                    rec_bytes_d = rec_size(remaining_d);
                    if (remaining_d != 32'd0) begin
                        state_d = FETCH;
                    end else begin
                        is_s7_d = 1'b1;
                        state_d = S_CHAR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: render the character the next state will present.
        cc_d     = is_s7_d ? 8'd5 : ({2'b00, rec_bytes_d} + 8'd5);
        addr_d   = is_s7_d ? start_addr_d : cur_addr_d;
        byte_d   = byte_at(state_d, dig_d, cc_d, addr_d, buf_d[dig_d[5:3]], sum_d);
        nibble_d = dig_d[0] ? byte_d[3:0] : byte_d[7:4];

        char_valid_d = state_d inside {S_CHAR, TYPE, COUNT, ADDR, DATA, CSUM, EOL};
        case (state_d)
            S_CHAR:                  char_out_d = 8'h53;
            TYPE:                    char_out_d = is_s7_d ? 8'h37 : 8'h33;
            COUNT, ADDR, DATA, CSUM: char_out_d = hex_char(nibble_d);
            EOL:                     char_out_d = 8'h0A;
            default:                 char_out_d = 8'h00;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            start_addr_q  <= '0;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            rec_bytes_q   <= '0;
            is_s7_q       <= 1'b0;
            dig_q         <= '0;
            sum_q         <= '0;
            issue_cnt_q   <= '0;
            recv_cnt_q    <= '0;
            rd_v1_q       <= 1'b0;
            rd_v2_q       <= 1'b0;
            mem_address_q <= '0;
            char_out_q    <= '0;
            char_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_addr_q  <= start_addr_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            rec_bytes_q   <= rec_bytes_d;
            is_s7_q       <= is_s7_d;
            dig_q         <= dig_d;
            sum_q         <= sum_d;
            issue_cnt_q   <= issue_cnt_d;
            recv_cnt_q    <= recv_cnt_d;
            rd_v1_q       <= rd_v1_d;
            rd_v2_q       <= rd_v2_d;
            mem_address_q <= mem_address_d;
            char_out_q    <= char_out_d;
            char_valid_q  <= char_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_buf
            always_ff @(posedge clock) begin
                if (!reset_n) buf_q[gi] <= '0;
                else          buf_q[gi] <= buf_d[gi];
            end
        end
    endgenerate

    assign mem_address = mem_address_q;
    assign mem_wren    = 1'b0;
    assign mem_data_in = '0;
    assign char_out    = char_out_q;
    assign char_valid  = char_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_srec_dumper.sv
// Directed bench for srec_dumper: expected S-record text is queued from a reference
// model when a dump is started and compared character by character as it is accepted.
`timescale 1ns/1ps
module tb_srec_dumper;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        char_ready = 1'b1;
    logic [0:31] start_address = '0;
    logic [0:31] length = '0;
    logic [0:31] mem_address, mem_data_in, mem_data_out;
    logic        mem_wren, char_valid, busy, done;
    logic [7:0]  char_out;

    int          checks = 0;
    int          failures = 0;
    int          chars_seen = 0;
    logic [7:0]  exp_q[$];
    bit          stall_prev = 1'b0;
    logic [7:0]  stall_char = '0;
    logic [7:0]  exp_c;
    logic [31:0] mem_rd_q = '0;

    srec_dumper #(.RECORD_BYTES(16)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .start_address(start_address), .length(length),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .char_out(char_out), .char_valid(char_valid),
        .char_ready(char_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8002_0000) return 32'h27BD_FFF8;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Synchronous memory: address registered, data visible the following cycle.
    always @(posedge clock) mem_rd_q <= mem_word(mem_address);
    assign mem_data_out = mem_rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_ch(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic push_hex(input logic [7:0] b);
        exp_q.push_back(hex_ch(b[7:4]));
        exp_q.push_back(hex_ch(b[3:0]));
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0A);
    endtask

    task automatic model_dump(input logic [31:0] addr, input logic [31:0] len);
        logic [31:0] a, rem, n, w;
        logic [7:0]  sum, b;
        a = addr;
        rem = len;
        while (rem != 0) begin
            n = (rem < 32'd16) ? rem : 32'd16;
            sum = 8'(n + 32'd5);
            exp_q.push_back("S");
            exp_q.push_back("3");
            push_hex(8'(n + 32'd5));
            for (int k = 0; k < 4; k++) begin
                b = 8'(a >> (24 - 8 * k));
                sum += b;
                push_hex(b);
            end
            for (int i = 0; i < int'(n / 4); i++) begin
                w = mem_word(a + 32'(4 * i));
                for (int k = 0; k < 4; k++) begin
                    b = 8'(w >> (24 - 8 * k));
                    sum += b;
                    push_hex(b);
                end
            end
            push_hex(~sum);
            exp_q.push_back(8'h0A);
            a += n;
            rem -= n;
        end
        exp_q.push_back("S");
        exp_q.push_back("7");
        push_hex(8'h05);
        sum = 8'h05;
        for (int k = 0; k < 4; k++) begin
            b = 8'(addr >> (24 - 8 * k));
            sum += b;
            push_hex(b);
        end
        push_hex(~sum);
        exp_q.push_back(8'h0A);
    endtask

    // Character sink: one comparison per accepted character, plus hold checks on stalls.
    always @(negedge clock) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("stall_hold", {23'd0, char_valid, char_out}, {23'd0, 1'b1, stall_char});
            if (char_valid && char_ready) begin
                chars_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_char", {24'd0, char_out}, 32'hFFFF_FFFF);
                end else begin
                    exp_c = exp_q.pop_front();
                    $display("char %0d: observed=%h expected=%h", chars_seen, char_out, exp_c);
                    check("char", {24'd0, char_out}, {24'd0, exp_c});
                end
                check("mem_wren", {31'd0, mem_wren}, 32'd0);
            end
            stall_prev = char_valid && !char_ready;
            stall_char = char_out;
        end
    end

    task automatic run_dump(input string name, input logic [31:0] addr, input logic [31:0] len,
                            input bit rnd, input bit poke);
        int          dn;
        int          tail;
        logic [31:0] addr0;
        addr0 = mem_address;
        dn = 0;
        tail = 0;
        @(posedge clock); #1;
        start = 1'b1;
        start_address = addr;
        length = len;
        for (int c = 0; c < 3000 && tail < 6; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (poke && (c == 3 || c == 11 || c == 25)) begin
                start = 1'b1;
                start_address = 32'h1234_5670;
                length = 32'd8;
            end
            if (done) begin
                dn++;
                if (poke) begin
                    start = 1'b1;
                    start_address = 32'h1234_5670;
                    length = 32'd8;
                end
            end
            if (dn > 0) tail++;
            char_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        start = 1'b0;
        char_ready = 1'b1;
        $display("dump %s: done_pulses=%0d left=%0d", name, dn, exp_q.size());
        check({name, "_done_pulses"}, dn, 1);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        check({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
        if (len == 32'd0) check({name, "_no_reads"}, mem_address, addr0);
        exp_q.delete();
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_char_out", {24'd0, char_out}, 32'd0);
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_data_in", mem_data_in, 32'd0);
        reset_n = 1'b1;

        push_str("S3098002000027BDFFF899");
        push_str("S7058002000078");
        run_dump("len4", 32'h8002_0000, 32'd4, 1'b0, 1'b0);

        push_str("S7058002000078");
        run_dump("len0", 32'h8002_0000, 32'd0, 1'b0, 1'b0);

        model_dump(32'h8002_0000, 32'd20);
        run_dump("len20", 32'h8002_0000, 32'd20, 1'b0, 1'b0);

        model_dump(32'h8002_0000, 32'd20);
        run_dump("len20_stall", 32'h8002_0000, 32'd20, 1'b1, 1'b0);

        // Reset in the middle of the first record's data field.
        model_dump(32'h8002_0000, 32'd20);
        base = chars_seen;
        @(posedge clock); #1;
        start = 1'b1;
        start_address = 32'h8002_0000;
        length = 32'd20;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 500 && chars_seen < base + 16; c++) @(posedge clock);
        #1;
        check("mid_data_reached", {31'd0, chars_seen >= base + 16}, 32'd1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("mid_rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        exp_q.delete();
        model_dump(32'h8002_0000, 32'd20);
        run_dump("after_reset", 32'h8002_0000, 32'd20, 1'b0, 1'b0);

        model_dump(32'h8002_0000, 32'd4);
        run_dump("start_while_busy", 32'h8002_0000, 32'd4, 1'b0, 1'b1);

        model_dump(32'hFFFF_FFF0, 32'd24);
        run_dump("wrap", 32'hFFFF_FFF0, 32'd24, 1'b1, 1'b0);

        model_dump(32'h0000_1000, 32'd32);
        run_dump("len32", 32'h0000_1000, 32'd32, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
